// File: rtl/i2c_target.sv
// i2c_target: I2C responder with an 8-bit register pointer and a byte-wide register port.
// SCL is input-only; SDA is driven open-drain via sda_oe (1 = pull low).
// Build option: define I2C_TARGET_GLITCH_FILTER_EN to add a 3-sample majority filter
// behind each synchronizer (rejects pulses of 1 clk or shorter, +2 clk latency).
module i2c_target #(
   parameter logic [6:0] TARGET_ADDR = 7'h42,
   parameter bit         PTR_AUTOINC = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       sda_oe,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       reg_we,
   output logic       reg_re,
   input  logic [7:0] reg_rdata,
   output logic       busy,
   output logic       stop_pulse
);

   typedef enum logic [3:0] {
      StIdle,
      StAddr,
      StAddrAck,
      StPtr,
      StPtrAck,
      StWdata,
      StWdataAck,
      StRdata,
      StRack,
      StIgnore
   } state_e;

   logic [1:0] scl_sync_q, sda_sync_q;
   logic       scl_c, sda_c;
   logic       scl_prev_q, sda_prev_q;
   logic       scl_rise, scl_fall, start_det, stop_det;

   state_e     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] shreg_q, shreg_d;
   logic       rw_q, rw_d;
   logic [7:0] ptr_q, ptr_d;
   logic [7:0] wdata_q, wdata_d;
   logic       we_q, we_d;
   logic       re_q, re_d;
   logic       re_pend_q;
   logic       oe_q, oe_d;
   logic       busy_q, busy_d;
   logic [7:0] rx_byte;

   // Two-flop synchronizers; idle bus level is high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scl_sync_q <= 2'b11;
         sda_sync_q <= 2'b11;
      end else begin
         scl_sync_q <= {scl_sync_q[0], scl_i};
         sda_sync_q <= {sda_sync_q[0], sda_i};
      end
   end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
   logic [1:0] scl_hist_q, sda_hist_q;
   logic       scl_filt_q, sda_filt_q;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   // Majority of the last three synchronized samples; a lone odd sample never wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scl_hist_q <= 2'b11;
         sda_hist_q <= 2'b11;
         scl_filt_q <= 1'b1;
         sda_filt_q <= 1'b1;
      end else begin
         scl_hist_q <= {scl_hist_q[0], scl_sync_q[1]};
         sda_hist_q <= {sda_hist_q[0], sda_sync_q[1]};
         scl_filt_q <= maj3(scl_sync_q[1], scl_hist_q[0], scl_hist_q[1]);
         sda_filt_q <= maj3(sda_sync_q[1], sda_hist_q[0], sda_hist_q[1]);
      end
   end

   assign scl_c = scl_filt_q;
   assign sda_c = sda_filt_q;
`else
   assign scl_c = scl_sync_q[1];
   assign sda_c = sda_sync_q[1];
`endif

   // Previous conditioned levels for edge and START/STOP detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
      end else begin
         scl_prev_q <= scl_c;
         sda_prev_q <= sda_c;
      end
   end

   assign scl_rise  = scl_c & ~scl_prev_q;
   assign scl_fall  = ~scl_c & scl_prev_q;
   assign start_det = scl_c & scl_prev_q & sda_prev_q & ~sda_c;
   assign stop_det  = scl_c & scl_prev_q & ~sda_prev_q & sda_c;

   // FSM and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= 4'd0;
         shreg_q   <= 8'd0;
         rw_q      <= 1'b0;
         ptr_q     <= 8'd0;
         wdata_q   <= 8'd0;
         we_q      <= 1'b0;
         re_q      <= 1'b0;
         re_pend_q <= 1'b0;
         oe_q      <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         shreg_q   <= shreg_d;
         rw_q      <= rw_d;
         ptr_q     <= ptr_d;
         wdata_q   <= wdata_d;
         we_q      <= we_d;
         re_q      <= re_d;
         re_pend_q <= re_q;
         oe_q      <= oe_d;
         busy_q    <= busy_d;
      end
   end

   // Next-state logic: START/STOP override everything, otherwise step the byte protocol.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shreg_d = shreg_q;
      rw_d    = rw_q;
      ptr_d   = ptr_q;
      wdata_d = wdata_q;
      we_d    = 1'b0;
      re_d    = 1'b0;
      oe_d    = oe_q;
      busy_d  = busy_q;
      rx_byte = {shreg_q[6:0], sda_c};

      // Read data arrives the cycle after the strobe; the address byte is no longer needed.
      if (re_pend_q) shreg_d = reg_rdata;

      if (start_det) begin
         state_d = StAddr;
         cnt_d   = 4'd0;
         oe_d    = 1'b0;
         busy_d  = 1'b0;
      end else if (stop_det) begin
         state_d = StIdle;
         cnt_d   = 4'd0;
         oe_d    = 1'b0;
         busy_d  = 1'b0;
      end else begin
         unique case (state_q)
            StAddr: begin
               if (scl_rise) begin
                  shreg_d = rx_byte;
                  cnt_d   = cnt_q + 4'd1;
                  if (cnt_q == 4'd7) begin
                     if (rx_byte[7:1] == TARGET_ADDR) begin
                        state_d = StAddrAck;
                        busy_d  = 1'b1;
                        rw_d    = rx_byte[0];
                     end else begin
                        state_d = StIgnore;
                     end
                  end
               end
            end
            StPtr: begin
               if (scl_rise) begin
                  shreg_d = rx_byte;
                  cnt_d   = cnt_q + 4'd1;
                  if (cnt_q == 4'd7) begin
                     ptr_d   = rx_byte;
                     state_d = StPtrAck;
                  end
               end
            end
            StWdata: begin
               if (scl_rise) begin
                  shreg_d = rx_byte;
                  cnt_d   = cnt_q + 4'd1;
                  if (cnt_q == 4'd7) begin
                     we_d    = 1'b1;
                     wdata_d = rx_byte;
                     state_d = StWdataAck;
                  end
               end
            end
            // cnt 8: waiting for the 8th fall to drive ACK; cnt 9: 9th rise seen, release next fall.
            StAddrAck, StPtrAck, StWdataAck: begin
               if (scl_rise) begin
                  cnt_d = 4'd9;
                  if (state_q == StAddrAck && rw_q) re_d = 1'b1;
               end else if (scl_fall) begin
                  if (cnt_q == 4'd8) begin
                     oe_d = 1'b1;
                  end else begin
                     oe_d  = 1'b0;
                     cnt_d = 4'd0;
                     if (state_q == StAddrAck) begin
                        if (rw_q) begin
                           state_d = StRdata;
                           oe_d    = ~shreg_q[7];
                           shreg_d = {shreg_q[6:0], 1'b0};
                        end else begin
                           state_d = StPtr;
                        end
                     end else begin
                        state_d = StWdata;
                        if (state_q == StWdataAck && PTR_AUTOINC) ptr_d = ptr_q + 8'd1;
                     end
                  end
               end
            end
            // MSB already on the bus at entry; each fall presents the next bit.
            StRdata: begin
               if (scl_rise) begin
                  cnt_d = cnt_q + 4'd1;
               end else if (scl_fall) begin
                  if (cnt_q == 4'd8) begin
                     oe_d    = 1'b0;
                     state_d = StRack;
                  end else begin
                     oe_d    = ~shreg_q[7];
                     shreg_d = {shreg_q[6:0], 1'b0};
                  end
               end
            end
            StRack: begin
               if (scl_rise) begin
                  if (!sda_c) begin
                     cnt_d = 4'd9;
                     re_d  = 1'b1;
                     if (PTR_AUTOINC) ptr_d = ptr_q + 8'd1;
                  end else begin
                     state_d = StIgnore;
                  end
               end else if (scl_fall && cnt_q == 4'd9) begin
                  state_d = StRdata;
                  cnt_d   = 4'd0;
                  oe_d    = ~shreg_q[7];
                  shreg_d = {shreg_q[6:0], 1'b0};
               end
            end
            StIdle, StIgnore: ;
            default: state_d = StIdle;
         endcase
      end
   end

   assign sda_oe     = oe_q;
   assign reg_addr   = ptr_q;
   assign reg_wdata  = wdata_q;
   assign reg_we     = we_q;
   assign reg_re     = re_q;
   // Drop busy in the same cycle the bus condition is seen.
   assign busy       = busy_q & ~stop_det & ~start_det;
   assign stop_pulse = stop_det;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bus-level master tasks, a register-pointer reference model,
// directed scenarios and randomized write/read transactions.
module tb_i2c_target;

   localparam int Q = 6;  // clk cycles per quarter SCL period

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       scl_m = 1'b1;
   logic       sda_m = 1'b1;
   logic       sda_oe;
   logic [7:0] reg_addr, reg_wdata, reg_rdata;
   logic       reg_we, reg_re, busy, stop_pulse;
   wire        sda_bus = sda_m & ~sda_oe;

   logic [7:0]  rom [256];
   logic [7:0]  wbuf [16];
   logic [15:0] we_log [$];
   logic [7:0]  re_log [$];
   int          stop_cnt = 0;
   bit          busy_seen = 1'b0;
   int          total = 0;
   int          bad = 0;
   logic [7:0]  mptr = 8'd0;

   always #5 clk = ~clk;

   assign reg_rdata = rom[reg_addr];

   i2c_target dut (
      .clk       (clk),
      .rst       (rst),
      .scl_i     (scl_m),
      .sda_i     (sda_bus),
      .sda_oe    (sda_oe),
      .reg_addr  (reg_addr),
      .reg_wdata (reg_wdata),
      .reg_we    (reg_we),
      .reg_re    (reg_re),
      .reg_rdata (reg_rdata),
      .busy      (busy),
      .stop_pulse(stop_pulse)
   );

   // Record register-port activity away from the active edge.
   always @(negedge clk) begin
      if (reg_we) we_log.push_back({reg_addr, reg_wdata});
      if (reg_re) re_log.push_back(reg_addr);
      if (stop_pulse) stop_cnt++;
      if (busy) busy_seen = 1'b1;
   end

   initial begin
      repeat (150000) @(posedge clk);
      $display("FAIL watchdog: cycles exceeded limit, got hang want finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] we_get(input int i);
      return (i < we_log.size()) ? {16'd0, we_log[i]} : 32'hDEAD_BEEF;
   endfunction

   function automatic logic [31:0] re_get(input int i);
      return (i < re_log.size()) ? {24'd0, re_log[i]} : 32'hDEAD_BEEF;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_logs();
      we_log.delete();
      re_log.delete();
      stop_cnt  = 0;
      busy_seen = 1'b0;
   endtask

   task automatic bus_start();
      sda_m = 1'b1; tick(Q);
      scl_m = 1'b1; tick(Q);
      sda_m = 1'b0; tick(Q);
      scl_m = 1'b0; tick(Q);
   endtask

   task automatic bus_stop();
      sda_m = 1'b0; tick(Q);
      scl_m = 1'b1; tick(Q);
      sda_m = 1'b1; tick(2 * Q);
   endtask

   task automatic clock_bit(input logic b, output logic seen);
      sda_m = b;    tick(Q);
      scl_m = 1'b1; tick(Q);
      seen  = sda_bus;
      tick(Q);
      scl_m = 1'b0; tick(Q);
   endtask

   // Same bit, with a single-clk low pulse on SCL in the middle of the high phase.
   task automatic clock_bit_glitch(input logic b);
      sda_m = b;    tick(Q);
      scl_m = 1'b1; tick(Q / 2);
      scl_m = 1'b0; tick(1);
      scl_m = 1'b1; tick(Q / 2 + Q - 1);
      scl_m = 1'b0; tick(Q);
   endtask

   task automatic write_byte(input logic [7:0] d, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) clock_bit(d[i], s);
      clock_bit(1'b1, s);
      ack = ~s;
   endtask

   task automatic read_byte(input logic master_ack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         clock_bit(1'b1, s);
         d[i] = s;
      end
      clock_bit(~master_ack, s);
   endtask

   // Write transaction: address byte, pointer byte, n data bytes from wbuf, STOP.
   task automatic do_write(input logic [7:0] addr_byte, input logic [7:0] p, input int n);
      logic       a;
      logic [7:0] ea;
      bit         match;
      match = (addr_byte[7:1] == 7'h42) && !addr_byte[0];
      clear_logs();
      bus_start();
      write_byte(addr_byte, a);
      check("wr_addr_ack", {31'd0, a}, {31'd0, match});
      write_byte(p, a);
      check("wr_ptr_ack", {31'd0, a}, {31'd0, match});
      for (int i = 0; i < n; i++) begin
         write_byte(wbuf[i], a);
         check("wr_data_ack", {31'd0, a}, {31'd0, match});
      end
      bus_stop();
      check("wr_we_count", we_log.size(), match ? n : 0);
      if (match) begin
         for (int i = 0; i < n; i++) begin
            ea = p + 8'(i);
            check("wr_we_entry", we_get(i), {16'd0, ea, wbuf[i]});
         end
         mptr = p + 8'(n);
      end
      check("wr_re_count", re_log.size(), 0);
      check("wr_stop_pulse", stop_cnt, 1);
      check("wr_busy_seen", {31'd0, busy_seen}, {31'd0, match});
      check("wr_busy_end", {31'd0, busy}, 32'd0);
   endtask

   // Read n bytes (n >= 1), optionally after setting the pointer and a repeated START.
   task automatic do_read(input bit set_ptr, input logic [7:0] p, input int n);
      logic       a;
      logic [7:0] d, q;
      q = set_ptr ? p : mptr;
      clear_logs();
      bus_start();
      if (set_ptr) begin
         write_byte(8'h84, a);
         check("rd_waddr_ack", {31'd0, a}, 32'd1);
         write_byte(p, a);
         check("rd_ptr_ack", {31'd0, a}, 32'd1);
         bus_start();
      end
      write_byte(8'h85, a);
      check("rd_addr_ack", {31'd0, a}, 32'd1);
      for (int i = 0; i < n; i++) begin
         read_byte(i != n - 1, d);
         check("rd_data", {24'd0, d}, {24'd0, rom[q + 8'(i)]});
      end
      check("rd_oe_after_nack", {31'd0, sda_oe}, 32'd0);
      bus_stop();
      check("rd_re_count", re_log.size(), n);
      for (int i = 0; i < n; i++) check("rd_re_addr", re_get(i), {24'd0, q + 8'(i)});
      check("rd_we_count", we_log.size(), 0);
      check("rd_stop_pulse", stop_cnt, 1);
      mptr = q + 8'(n - 1);
   endtask

   initial begin
      logic       a;
      logic [7:0] ab, seen_byte;
      logic [6:0] a7;
      bit         exp_ack;
      int         kind, n;
      logic [7:0] p;

      for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
      rom[8'h20] = 8'h3C;
      rom[8'h21] = 8'hC3;
      rom[8'h30] = 8'h12;

      tick(4);
      check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
      check("rst_reg_addr", {24'd0, reg_addr}, 32'd0);
      check("rst_reg_wdata", {24'd0, reg_wdata}, 32'd0);
      check("rst_reg_we", {31'd0, reg_we}, 32'd0);
      check("rst_reg_re", {31'd0, reg_re}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_stop_pulse", {31'd0, stop_pulse}, 32'd0);
      rst = 1'b0;
      tick(4);

      // Basic write, combined read, address mismatch, pointer wrap.
      wbuf[0] = 8'hA5;
      wbuf[1] = 8'h5A;
      do_write(8'h84, 8'h10, 2);
      do_read(1'b1, 8'h20, 2);
      do_write(8'h90, 8'h11, 0);
      wbuf[0] = 8'h77;
      wbuf[1] = 8'h88;
      do_write(8'h84, 8'hFF, 2);
      check("wrap_ptr", {24'd0, reg_addr}, {24'd0, mptr});

      // Reset while the target drives a 0 data bit.
      do_write(8'h84, 8'h30, 0);
      clear_logs();
      bus_start();
      write_byte(8'h85, a);
      check("rstmid_addr_ack", {31'd0, a}, 32'd1);
      check("rstmid_oe_driving", {31'd0, sda_oe}, 32'd1);
      rst = 1'b1;
      #1;
      check("rstmid_oe_async", {31'd0, sda_oe}, 32'd0);
      tick(2);
      rst = 1'b0;
      mptr = 8'd0;
      check("rstmid_ptr", {24'd0, reg_addr}, 32'd0);
      tick(2);
      bus_stop();
      wbuf[0] = 8'h5C;
      do_write(8'h84, 8'h40, 1);

      // SCL glitch during the first address bit.
      ab = 8'h84;
      seen_byte = {ab[7], ab[7:1]};
`ifdef I2C_TARGET_GLITCH_FILTER_EN
      exp_ack = 1'b1;
`else
      exp_ack = (seen_byte[7:1] == 7'h42);
`endif
      clear_logs();
      bus_start();
      clock_bit_glitch(ab[7]);
      for (int i = 6; i >= 0; i--) clock_bit(ab[i], a);
      clock_bit(1'b1, a);
      check("glitch_addr_ack", {31'd0, ~a}, {31'd0, exp_ack});
      bus_stop();
      check("glitch_we_count", we_log.size(), 0);
      check("glitch_ptr", {24'd0, reg_addr}, {24'd0, mptr});

      // Randomized traffic against the pointer model.
      for (int t = 0; t < 24; t++) begin
         kind = int'($urandom_range(0, 3));
         p = ($urandom_range(0, 3) == 0) ? 8'hFE : 8'($urandom);
         unique case (kind)
            0: begin
               n = int'($urandom_range(0, 3));
               for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
               do_write(8'h84, p, n);
            end
            1: do_read(1'b1, p, int'($urandom_range(1, 3)));
            2: do_read(1'b0, p, int'($urandom_range(1, 3)));
            default: begin
               do a7 = 7'($urandom); while (a7 == 7'h42);
               wbuf[0] = 8'($urandom);
               do_write({a7, 1'b0}, p, 1);
            end
         endcase
      end
      check("final_ptr", {24'd0, reg_addr}, {24'd0, mptr});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/i2c_target.md
# i2c_target

I2C target (responder) with an 8-bit register pointer, the counterpart to the core's I2C master. It sits in `chip_core` behind two bidir pads: SCL is input-only, and SDA is driven open-drain through the pad OE. Board-level tests can loop the on-chip master back onto it, and an external controller can use it to read and write core registers. It decodes START, STOP, repeated START, address, pointer and data bytes. Accesses go through a simple byte-wide register port.

## Interface
Parameters:
- `TARGET_ADDR`, default 7'h42: 7-bit target address.
- `PTR_AUTOINC`, default 1: 1 = pointer increments after every data byte; 0 = pointer is held.

Ports:
- `clk`  in  1: system clock; must be at least 16× the SCL frequency.
- `rst`  in  1: asynchronous, active-high reset.
- `scl_i`  in  1: SCL from pad `Y`; asynchronous.
- `sda_i`  in  1: SDA from pad `Y`; asynchronous.
- `sda_oe`  out  1: 1 = pull SDA low. Pad `A` is tied to 0 and pad `OE` = `sda_oe`.
- `reg_addr`  out  8: current register pointer.
- `reg_wdata`  out  8: write data; valid while `reg_we` is high.
- `reg_we`  out  1: one-cycle write strobe.
- `reg_re`  out  1: one-cycle read strobe.
- `reg_rdata`  in  8: sampled on the cycle after `reg_re`.
- `busy`  out  1: high from an address match until STOP or START.
- `stop_pulse`  out  1: one-cycle pulse on every detected STOP.

## Operation
- Input conditioning: `scl_i` and `sda_i` each pass through a 2-flop synchronizer. Edges are detected on the synchronized values.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high. Both are valid in every state.
  - START (including repeated START) → ADDR, bit counter cleared, `sda_oe`=0.
  - STOP → IDLE, `sda_oe`=0.
- Bits are sampled on SCL rising edges, MSB first. `sda_oe` changes only after an SCL falling edge.
- State transitions:
  - IDLE → ADDR on START.
  - ADDR: shift in 8 bits. If [7:1] ≠ `TARGET_ADDR` → IGNORE. On a match → ADDR_ACK and `busy`=1.
  - ADDR_ACK: drive ACK (`sda_oe`=1) from the 8th falling edge to the 9th falling edge.
    - R/W=0 → PTR.
    - R/W=1 → `reg_re` pulses at the 9th rising edge, then RDATA.
  - PTR: 8 bits load the pointer. ACK, then → WDATA.
  - WDATA: 8 bits; `reg_we` pulses with `reg_wdata` and `reg_addr` = pointer. ACK, then pointer+1 when `PTR_AUTOINC`, then → WDATA.
  - RDATA: shift out the latched `reg_rdata`. Drive 0 bits as `sda_oe`=1; release for 1 bits. Then → RACK.
  - RACK: release SDA and sample the master's response at the 9th rising edge.
    - ACK (SDA=0): pointer+1 (if `PTR_AUTOINC`), `reg_re` pulses, → RDATA.
    - NACK: → IGNORE.
  - IGNORE: SDA stays released; wait for START or STOP.
- Pointer arithmetic: 8-bit; 0xFF+1 wraps to 0x00. The pointer persists across transactions, so write-pointer followed by repeated-START read works.
- The target never NACKs a byte addressed to it. It never stretches the clock.

## Timing
- Reset values: `sda_oe`=0, `reg_addr`=0, `reg_wdata`=0, `reg_we`=0, `reg_re`=0, `busy`=0, `stop_pulse`=0. State = IDLE.
- Reset asserted mid-transfer: `sda_oe` releases immediately (asynchronous).
- Pad to edge detect: 2 clk (4 clk with the filter).
- `sda_oe` update: 1 clk after the detected SCL falling edge. This gives SDA hold time ≥ 3 clk.
- `reg_we`: asserted 1 clk after the 8th data rising edge is detected.
- `reg_re` → `reg_rdata` latched on the next clk. This is well before the next SCL falling edge.
- `stop_pulse` and `busy` deassertion: same cycle as STOP detection.

## Configuration
- `I2C_TARGET_GLITCH_FILTER_EN`: adds a 3-sample majority filter after each synchronizer. Pulses of 1 clk or shorter are rejected, and latency rises by 2 clk.
- Without the macro: synchronizer only, no filtering.

## Test plan
- Write: START, 0x84, 0x10, 0xA5, 0x5A, STOP → ACK on all 4 bytes; `reg_we` at addr 0x10 data 0xA5, then at 0x11 data 0x5A; `stop_pulse` once.
- Combined read: START, 0x84, 0x20, repeated START, 0x85; `reg_rdata`=0x3C then 0xC3; master ACKs then NACKs, STOP → bus carries 0x3C then 0xC3; `reg_re` at 0x20 and 0x21; `sda_oe`=0 after the NACK.
- Address mismatch: START, 0x90, 0x11, STOP → no ACK, no strobes, `busy` stays 0.
- Wrap: pointer 0xFF, write 2 bytes → `reg_we` at 0xFF then 0x00.
- Reset mid-read: assert `rst` while driving a 0 bit → `sda_oe`=0 immediately; the next transaction behaves normally.
- Filter build: a 1-clk low glitch on SCL during the ADDR byte → bit count unchanged and the transfer still ACKs. The same stimulus without the macro → the transfer is not ACKed.
